// File: rtl/mult_controller.sv
// mult_controller: queues signed/unsigned 32x32 multiply requests, drives an
// unsigned downstream multiplier with operand magnitudes and re-applies the sign.
`default_nettype none

module mult_controller #(
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        mult_begin,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  input  logic [63:0] mult_product,
  input  logic        mult_end,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        busy
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [64:0]       mem_q [QDEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q;
  logic [31:0]       op1_q, op1_d, op2_q, op2_d;
  logic              neg_q, neg_d;
  logic              first_q, first_d;
  logic [63:0]       res_q, res_d;
  logic              push, pop, full;
  logic              head_sgn;
  logic [31:0]       head_a, head_b;

  assign full      = (count_q == CW'(QDEPTH));
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign {head_sgn, head_a, head_b} = mem_q[rptr_q];

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    neg_d   = neg_q;
    first_d = first_q;
    res_d   = res_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          // Negating 0x80000000 wraps to itself, which is its correct magnitude.
          op1_d   = (head_sgn && head_a[31]) ? (~head_a + 32'd1) : head_a;
          op2_d   = (head_sgn && head_b[31]) ? (~head_b + 32'd1) : head_b;
          neg_d   = head_sgn && (head_a[31] ^ head_b[31]);
          first_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        first_d = 1'b0;
        if (!first_q && mult_end) begin
          res_d   = neg_q ? (~mult_product + 64'd1) : mult_product;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      neg_q   <= 1'b0;
      first_q <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      neg_q   <= neg_d;
      first_q <= first_d;
      res_q   <= res_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {req_signed, req_a, req_b};
  end

  assign mult_begin = (state_q == ISSUE);
  assign mult_op1   = op1_q;
  assign mult_op2   = op2_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_hi     = res_q[63:32];
  assign rsp_lo     = res_q[31:0];
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_mult_controller.sv
// Directed self-checking bench for mult_controller with a behavioural multiplier.
`default_nettype none

module tb_mult_controller;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_signed = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        mult_begin;
  logic [31:0] mult_op1, mult_op2;
  logic [63:0] mult_product;
  logic        mult_end;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_hi, rsp_lo;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mult_controller #(.QDEPTH(2)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
    .req_a(req_a), .req_b(req_b),
    .mult_begin(mult_begin), .mult_op1(mult_op1), .mult_op2(mult_op2),
    .mult_product(mult_product), .mult_end(mult_end),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier32 stand-in: mult_end rises 4 edges into a mult_begin run, holds until begin drops.
  logic [2:0] mcnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcnt <= '0; mult_end <= 1'b0; mult_product <= '0;
    end else if (!mult_begin) begin
      mcnt <= '0; mult_end <= 1'b0;
    end else if (mcnt == 3'd3) begin
      mult_end     <= 1'b1;
      mult_product <= {32'd0, mult_op1} * {32'd0, mult_op2};
    end else begin
      mcnt <= mcnt + 3'd1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_one(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, output logic [31:0] o1, output logic [31:0] o2);
    logic got, prev_end, beg_ok;
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1; req_signed = sgn; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_beg_lat0"}, mult_begin, 0);
    chk({tag, "_busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "_beg_lat1"}, mult_begin, 1);
    o1 = mult_op1; o2 = mult_op2;
    got = 1'b0; prev_end = mult_end; beg_ok = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        chk({tag, "_end_to_rsp"}, prev_end, 1);
        chk({tag, "_result"}, {rsp_hi, rsp_lo}, exp);
      end else begin
        if (!mult_begin) beg_ok = 1'b0;
        prev_end = mult_end;
      end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $error("FAIL %s_timeout observed=no_rsp expected=rsp_valid", tag);
    end
    chk({tag, "_beg_held"}, beg_ok, 1);
    @(negedge clk);
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
    chk({tag, "_op1_retain"}, mult_op1, o1);
  endtask

  logic [31:0] o1, o2;
  logic [63:0] bp_exp [4];
  logic        bp_sgn [4];
  logic [31:0] bp_a [4], bp_b [4];
  int          idx, low_cnt;
  logic        prev_beg, acc_pend, gap_ok, order_ok;

  initial begin
    // reset state
    #2;
    chk("rst_beg", mult_begin, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp", {rsp_hi, rsp_lo}, 64'd0);
    chk("rst_ops", {mult_op1, mult_op2}, 64'd0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);

    run_one("u1111", 1'b0, 32'h00001111, 32'h00001111, 64'h00000000_01234321, o1, o2);
    run_one("u2xff", 1'b0, 32'h00000002, 32'hFFFFFFFF, 64'h00000001_FFFFFFFE, o1, o2);
    chk("u2xff_op2", o2, 32'hFFFFFFFF);
    run_one("s2xff", 1'b1, 32'h00000002, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFE, o1, o2);
    chk("s2xff_op2", o2, 32'h00000001);
    run_one("s7f", 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, o1, o2);
    run_one("s80", 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, o1, o2);
    chk("s80_op1", o1, 32'h80000000);
    chk("s80_op2", o2, 32'h80000000);

    // backpressure: four requests with rsp_ready low
    bp_sgn[0] = 1'b0; bp_a[0] = 32'd3;          bp_b[0] = 32'd5;          bp_exp[0] = 64'd15;
    bp_sgn[1] = 1'b1; bp_a[1] = 32'hFFFFFFFD;   bp_b[1] = 32'd5;          bp_exp[1] = 64'hFFFFFFFF_FFFFFFF1;
    bp_sgn[2] = 1'b0; bp_a[2] = 32'hFFFFFFFF;   bp_b[2] = 32'hFFFFFFFF;   bp_exp[2] = 64'hFFFFFFFE_00000001;
    bp_sgn[3] = 1'b1; bp_a[3] = 32'hFFFFFFFF;   bp_b[3] = 32'hFFFFFFFF;   bp_exp[3] = 64'd1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_ready%0d", k), req_ready, 1);
      req_valid = 1'b1; req_signed = bp_sgn[k]; req_a = bp_a[k]; req_b = bp_b[k];
    end
    @(negedge clk);
    req_signed = bp_sgn[3]; req_a = bp_a[3]; req_b = bp_b[3];
    chk("bp_full_ready", req_ready, 0);
    for (int i = 0; i < 100 && !rsp_valid; i++) @(negedge clk);
    chk("bp_first_rsp", {rsp_valid, rsp_hi, rsp_lo}, {1'b1, bp_exp[0]});
    repeat (3) @(negedge clk);
    chk("bp_hold_rsp", {rsp_valid, rsp_hi, rsp_lo}, {1'b1, bp_exp[0]});
    chk("bp_hold_ready", req_ready, 0);
    chk("bp_hold_beg", mult_begin, 0);
    rsp_ready = 1'b1;
    idx = 0; low_cnt = 0; prev_beg = 1'b0; acc_pend = 1'b0; gap_ok = 1'b1; order_ok = 1'b1;
    for (int i = 0; i < 300 && idx < 4; i++) begin
      if (acc_pend) begin req_valid = 1'b0; acc_pend = 1'b0; end
      if (req_valid && req_ready) acc_pend = 1'b1;
      if (rsp_valid) begin
        if ({rsp_hi, rsp_lo} !== bp_exp[idx]) order_ok = 1'b0;
        idx++;
      end
      if (mult_begin) begin
        if (!prev_beg && low_cnt < 2) gap_ok = 1'b0;
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      prev_beg = mult_begin;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_count", idx, 4);
    chk("bp_order", order_ok, 1);
    chk("bp_gap", gap_ok, 1);
    chk("bp_idle", {busy, req_ready}, 2'b01);

    // reset mid-ISSUE with one entry queued
    @(negedge clk);
    req_valid = 1'b1; req_signed = 1'b0; req_a = 32'd7; req_b = 32'd9;
    @(negedge clk);
    req_a = 32'd11; req_b = 32'd13;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_beg_pre", mult_begin, 1);
    chk("rstmid_ready_pre", req_ready, 1);
    #2 resetn = 1'b0;
    #1;
    chk("rstmid_beg", mult_begin, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", req_ready, 1);
    @(negedge clk); resetn = 1'b1;
    begin
      logic saw_rsp, saw_busy;
      saw_rsp = 1'b0; saw_busy = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (rsp_valid) saw_rsp = 1'b1;
        if (busy) saw_busy = 1'b1;
      end
      chk("rstmid_no_rsp", saw_rsp, 0);
      chk("rstmid_no_busy", saw_busy, 0);
    end
    run_one("post_rst", 1'b1, 32'hFFFFFFF9, 32'd6, 64'hFFFFFFFF_FFFFFFD6, o1, o2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/mult_controller.md
MULT_CONTROLLER -- requirements
Module: mult_controller

Interface
REQ-001 Parameter: QDEPTH, 2, request queue depth in entries; power of two, >=2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  queue can accept a request.
REQ-006 req_signed  input  1  1 = two's-complement multiply, 0 = unsigned.
REQ-007 req_a, req_b  input  32 each  multiplicand, multiplier.
REQ-008 mult_begin  output  1  start/hold to the downstream Multiplier32.
REQ-009 mult_op1, mult_op2  output  32 each  unsigned operand magnitudes to the multiplier.
REQ-010 mult_product  input  64  unsigned product from the multiplier.
REQ-011 mult_end  input  1  multiplier done.
REQ-012 rsp_valid  output  1  result present.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_hi, rsp_lo  output  32 each  result bits [63:32], [31:0].
REQ-015 busy  output  1  high when state != IDLE or the queue is non-empty.

Function
REQ-016 Push occurs on a rising edge with req_valid && req_ready; the entry stores {req_signed, req_a, req_b}.
REQ-017 req_ready = !full; no pop-through, so a full queue refuses a request even when a pop occurs in the same cycle.
REQ-018 Queue is FIFO with wrap-around read/write pointers and a count; a push to an empty queue is not bypassed to the FSM.
REQ-019 FSM states: IDLE, ISSUE, RESP.
REQ-020 IDLE: if queue non-empty, pop head, register operands, go to ISSUE; otherwise stay.
REQ-021 Operand preparation: if signed, mult_op = |x| and neg = a[31]^b[31]; |0x80000000| = 0x80000000; if unsigned, mult_op = x and neg = 0.
REQ-022 ISSUE: mult_begin = 1, mult_op1/mult_op2 held stable; mult_end is ignored in the first ISSUE cycle.
REQ-023 ISSUE, on mult_end = 1 (not the first cycle): capture result = neg ? (~mult_product + 1) mod 2^64 : mult_product into rsp_hi/rsp_lo, drop mult_begin, go to RESP.
REQ-024 RESP: rsp_valid = 1 with rsp_hi/rsp_lo stable; on rsp_ready go to IDLE; rsp_valid and rsp_hi/rsp_lo hold while rsp_ready = 0.
REQ-025 mult_begin is registered and is low for at least 2 cycles (RESP, IDLE) between consecutive operations.
REQ-026 Latency: accept at edge E0 into an empty queue with FSM in IDLE; mult_begin rises after E1; rsp_valid rises on the edge after mult_end is sampled high.
REQ-027 Pushes continue during ISSUE and RESP; results are returned in request order.
REQ-028 mult_op1/mult_op2 retain their last value outside ISSUE.

Reset
REQ-029 resetn low clears immediately, regardless of clock: FSM = IDLE, queue empty (pointers and count 0), mult_begin = 0, mult_op1/mult_op2 = 0, rsp_valid = 0, rsp_hi/rsp_lo = 0, busy = 0, req_ready = 1.
REQ-030 Reset during ISSUE or RESP drops mult_begin and rsp_valid at once; the in-flight result and all queued requests are discarded.

Verification (bench uses Multiplier32 as the downstream block; rsp_ready = 1 unless stated)
REQ-031 Unsigned 0x00001111 x 0x00001111 -> rsp_hi = 0x00000000, rsp_lo = 0x01234321; mult_begin high from the cycle after accept until mult_end.
REQ-032 Inputs 0x00000002 x 0xFFFFFFFF: unsigned -> 0x00000001_FFFFFFFE; signed -> 0xFFFFFFFF_FFFFFFFE; mult_op2 = 0x00000001 in the signed case.
REQ-033 Signed 0x7FFFFFFF x 0x7FFFFFFF -> 0x3FFFFFFF_00000001; signed 0x80000000 x 0x80000000 -> 0x40000000_00000000.
REQ-034 Backpressure, QDEPTH = 2, rsp_ready = 0: 4 back-to-back requests; first issued, next 2 queued, req_ready = 0 with the 4th pending; after rsp_ready is raised, 4 results return in order, each with a mult_begin low gap of at least 2 cycles.
REQ-035 resetn pulsed low mid-ISSUE with 1 entry queued -> mult_begin = 0 within the same cycle; no rsp_valid afterwards; busy = 0; req_ready = 1; a new request after reset completes correctly.
